mvu_seq_ctrl: RTL and testbench

Sequencer for the baseline MVU datapath. It accepts one matrix-vector command and streams the input vector into the VRF write port. It then sweeps VRF/MRF read addresses tile by tile with first/last accumulator strobes, issues ORF writes after the fixed reduction latency, and pulses done. It sits between the command/vector source and the MVU (VRF, MRF, LDPE array, ORF).

---
 rtl/mvu_seq_ctrl_pkg.sv | 26 ++
 rtl/mvu_wb_delay.sv | 37 +++
 rtl/mvu_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mvu_seq_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_seq_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : mvu_seq_ctrl_pkg
// Brief   : State encoding and default widths for the MVU sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mvu_seq_ctrl_pkg;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE    = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_LOAD    = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_COMPUTE = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_DRAIN   = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_DONE    = 3'd4;

    localparam int c_DEF_VRF_AWIDTH = 9;
    localparam int c_DEF_VRF_DWIDTH = 64;
    localparam int c_DEF_MRF_AWIDTH = 9;
    localparam int c_DEF_ORF_AWIDTH = 9;
    localparam int c_DEF_RED_LAT    = 10;

endpackage

`default_nettype wire

// File: rtl/mvu_wb_delay.sv
//------------------------------------------------------------------------------
// Module  : mvu_wb_delay
// Brief   : DEPTH-stage valid shift register with synchronous clear.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mvu_wb_delay #(
    parameter int DEPTH = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    output logic o_valid
);

    generate
        if (DEPTH == 1) begin : g_single
            logic r_q;
            always_ff @(posedge clk) begin
                if (rst) r_q <= 1'b0;
                else     r_q <= i_valid;
            end
            assign o_valid = r_q;
        end else begin : g_chain
            logic [DEPTH-1:0] r_sr;
            always_ff @(posedge clk) begin
                if (rst) r_sr <= '0;
                else     r_sr <= {r_sr[DEPTH-2:0], i_valid};
            end
            assign o_valid = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mvu_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module  : mvu_seq_ctrl
// Brief   : Loads a vector into the VRF, sweeps VRF/MRF tile by tile and
//           issues ORF writes after the reduction latency.
//           Optional macro MVU_SEQ_CTRL_VEC_REUSE_EN adds cmd_reuse.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mvu_seq_ctrl
    import mvu_seq_ctrl_pkg::*;
#(
    parameter int VRF_AWIDTH = c_DEF_VRF_AWIDTH,
    parameter int VRF_DWIDTH = c_DEF_VRF_DWIDTH,
    parameter int MRF_AWIDTH = c_DEF_MRF_AWIDTH,
    parameter int ORF_AWIDTH = c_DEF_ORF_AWIDTH,
    parameter int RED_LAT    = c_DEF_RED_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [VRF_AWIDTH:0]   cmd_vlen,
    input  logic [ORF_AWIDTH:0]   cmd_ntiles,
    input  logic [ORF_AWIDTH-1:0] cmd_orf_base,
`ifdef MVU_SEQ_CTRL_VEC_REUSE_EN
    input  logic                  cmd_reuse,
`endif
    input  logic                  vec_in_valid,
    output logic                  vec_in_ready,
    input  logic [VRF_DWIDTH-1:0] vec_in_data,
    output logic                  vrf_we,
    output logic [VRF_AWIDTH-1:0] vrf_wr_addr,
    output logic [VRF_DWIDTH-1:0] vrf_wr_data,
    output logic [VRF_AWIDTH-1:0] vrf_rd_addr,
    output logic [MRF_AWIDTH-1:0] mrf_rd_addr,
    output logic                  mvu_en,
    output logic                  mvu_first,
    output logic                  mvu_last,
    output logic                  orf_we,
    output logic [ORF_AWIDTH-1:0] orf_wr_addr,
    output logic                  busy,
    output logic                  done
);

    localparam logic [VRF_AWIDTH:0] c_VLEN_MAX = {1'b1, {VRF_AWIDTH{1'b0}}};

    logic [c_STATE_W-1:0]  r_state;
    logic [c_STATE_W-1:0]  w_state_nxt;
    logic [VRF_AWIDTH:0]   r_vlen;
    logic [VRF_AWIDTH:0]   r_wcnt;
    logic [VRF_AWIDTH:0]   r_col;
    logic [VRF_AWIDTH:0]   w_vlen_clamp;
    logic [ORF_AWIDTH:0]   r_ntiles;
    logic [ORF_AWIDTH:0]   r_tile;
    logic [ORF_AWIDTH:0]   r_wb_cnt;
    logic [ORF_AWIDTH:0]   w_wb_nxt;
    logic [ORF_AWIDTH-1:0] r_base;
    logic [MRF_AWIDTH-1:0] r_mrf_ptr;
    logic                  w_vec_hs;
    logic                  w_load_last;
    logic                  w_col_last;
    logic                  w_tile_last;
    logic                  w_reuse;
    logic                  w_wb_valid;

    assign w_vlen_clamp = (cmd_vlen > c_VLEN_MAX) ? c_VLEN_MAX : cmd_vlen;
    assign w_vec_hs     = vec_in_valid & vec_in_ready;
    assign w_load_last  = (r_wcnt == r_vlen - 1'b1);
    assign w_col_last   = (r_col == r_vlen - 1'b1);
    assign w_tile_last  = (r_tile == r_ntiles - 1'b1);
    assign w_wb_nxt     = r_wb_cnt + {{ORF_AWIDTH{1'b0}}, orf_we};

`ifdef MVU_SEQ_CTRL_VEC_REUSE_EN
    logic r_vec_loaded;

    always_ff @(posedge clk) begin
        if (rst)
            r_vec_loaded <= 1'b0;
        else if (w_vec_hs && w_load_last)
            r_vec_loaded <= 1'b1;
    end

    assign w_reuse = cmd_reuse & r_vec_loaded;
`else
    assign w_reuse = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_ntiles == '0)
                        w_state_nxt = c_ST_DONE;
                    else if (w_reuse)
                        w_state_nxt = c_ST_COMPUTE;
                    else if (w_vlen_clamp == '0)
                        w_state_nxt = c_ST_DONE;
                    else
                        w_state_nxt = c_ST_LOAD;
                end
            end
            c_ST_LOAD:    if (w_vec_hs && w_load_last) w_state_nxt = c_ST_COMPUTE;
            c_ST_COMPUTE: if (w_col_last && w_tile_last) w_state_nxt = c_ST_DRAIN;
            // Count the write landing this cycle so done follows it directly.
            c_ST_DRAIN:   if (w_wb_nxt == r_ntiles) w_state_nxt = c_ST_DONE;
            c_ST_DONE:    w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready    = 1'b0;
        vec_in_ready = 1'b0;
        mvu_en       = 1'b0;
        done         = 1'b0;
        busy         = (r_state != c_ST_IDLE);
        case (r_state)
            c_ST_IDLE:    cmd_ready    = 1'b1;
            c_ST_LOAD:    vec_in_ready = 1'b1;
            c_ST_COMPUTE: mvu_en       = 1'b1;
            c_ST_DONE:    done         = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vlen    <= '0;
            r_wcnt    <= '0;
            r_col     <= '0;
            r_ntiles  <= '0;
            r_tile    <= '0;
            r_wb_cnt  <= '0;
            r_base    <= '0;
            r_mrf_ptr <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_wcnt    <= '0;
                    r_col     <= '0;
                    r_tile    <= '0;
                    r_wb_cnt  <= '0;
                    r_mrf_ptr <= '0;
                    if (cmd_valid) begin
                        r_ntiles <= cmd_ntiles;
                        r_base   <= cmd_orf_base;
                    end
                    // Stored length is kept for reuse, so only real loads replace it.
                    if (w_state_nxt == c_ST_LOAD)
                        r_vlen <= w_vlen_clamp;
                end
                c_ST_LOAD: if (w_vec_hs) r_wcnt <= r_wcnt + 1'b1;
                c_ST_COMPUTE: begin
                    r_mrf_ptr <= r_mrf_ptr + 1'b1;
                    if (w_col_last) begin
                        r_col  <= '0;
                        r_tile <= r_tile + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                default: ;
            endcase
            if (orf_we)
                r_wb_cnt <= w_wb_nxt;
        end
    end

    assign vrf_we      = w_vec_hs;
    assign vrf_wr_addr = r_wcnt[VRF_AWIDTH-1:0];
    assign vrf_wr_data = w_vec_hs ? vec_in_data : '0;
    assign vrf_rd_addr = r_col[VRF_AWIDTH-1:0];
    assign mrf_rd_addr = r_mrf_ptr;
    assign mvu_first   = mvu_en & (r_col == '0);
    assign mvu_last    = mvu_en & w_col_last;
    assign orf_we      = w_wb_valid;
    assign orf_wr_addr = r_base + r_wb_cnt[ORF_AWIDTH-1:0];

    mvu_wb_delay #(
        .DEPTH (RED_LAT)
    ) u_wb_delay (
        .clk     (clk),
        .rst     (rst),
        .i_valid (mvu_last),
        .o_valid (w_wb_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_mvu_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_mvu_seq_ctrl
// Brief   : Directed self-checking bench for mvu_seq_ctrl (default parameters).
//           Reuse scenario runs when MVU_SEQ_CTRL_VEC_REUSE_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mvu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_vlen = '0;
    logic [9:0]  cmd_ntiles = '0;
    logic [8:0]  cmd_orf_base = '0;
`ifdef MVU_SEQ_CTRL_VEC_REUSE_EN
    logic        cmd_reuse = 1'b0;
`endif
    logic        vec_in_valid = 1'b0;
    logic        vec_in_ready;
    logic [63:0] vec_in_data = '0;
    logic        vrf_we;
    logic [8:0]  vrf_wr_addr;
    logic [63:0] vrf_wr_data;
    logic [8:0]  vrf_rd_addr;
    logic [8:0]  mrf_rd_addr;
    logic        mvu_en, mvu_first, mvu_last, orf_we, busy, done;
    logic [8:0]  orf_wr_addr;

    mvu_seq_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_vlen     (cmd_vlen),
        .cmd_ntiles   (cmd_ntiles),
        .cmd_orf_base (cmd_orf_base),
`ifdef MVU_SEQ_CTRL_VEC_REUSE_EN
        .cmd_reuse    (cmd_reuse),
`endif
        .vec_in_valid (vec_in_valid),
        .vec_in_ready (vec_in_ready),
        .vec_in_data  (vec_in_data),
        .vrf_we       (vrf_we),
        .vrf_wr_addr  (vrf_wr_addr),
        .vrf_wr_data  (vrf_wr_data),
        .vrf_rd_addr  (vrf_rd_addr),
        .mrf_rd_addr  (mrf_rd_addr),
        .mvu_en       (mvu_en),
        .mvu_first    (mvu_first),
        .mvu_last     (mvu_last),
        .orf_we       (orf_we),
        .orf_wr_addr  (orf_wr_addr),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    // Event log captured mid-cycle, tagged with the cycle number.
    int          q_vw_addr[$], q_vw_cyc[$];
    logic [63:0] q_vw_data[$];
    int          q_b_mrf[$], q_b_vrf[$], q_b_cyc[$];
    logic [1:0]  q_b_fl[$];
    int          q_o_addr[$], q_o_cyc[$];
    int          n_done, done_cyc, acc_cyc, n_rdy;

    always @(negedge clk) begin
        if (vrf_we) begin
            q_vw_addr.push_back(int'(vrf_wr_addr));
            q_vw_cyc.push_back(cyc);
            q_vw_data.push_back(vrf_wr_data);
        end
        if (mvu_en) begin
            q_b_mrf.push_back(int'(mrf_rd_addr));
            q_b_vrf.push_back(int'(vrf_rd_addr));
            q_b_fl.push_back({mvu_first, mvu_last});
            q_b_cyc.push_back(cyc);
        end
        if (orf_we) begin
            q_o_addr.push_back(int'(orf_wr_addr));
            q_o_cyc.push_back(cyc);
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (vec_in_ready) n_rdy++;
    end

    task automatic clear_mon();
        q_vw_addr.delete(); q_vw_cyc.delete(); q_vw_data.delete();
        q_b_mrf.delete(); q_b_vrf.delete(); q_b_cyc.delete(); q_b_fl.delete();
        q_o_addr.delete(); q_o_cyc.delete();
        n_done = 0; done_cyc = -1; acc_cyc = -1; n_rdy = 0;
    endtask

    // Entered just after a rising edge while the DUT is idle.
    task automatic do_cmd(input int vlen, input int ntiles, input int base);
        clear_mon();
        cmd_vlen     = 10'(vlen);
        cmd_ntiles   = 10'(ntiles);
        cmd_orf_base = 9'(base);
        cmd_valid    = 1'b1;
        @(posedge clk); #1;
        cmd_valid    = 1'b0;
    endtask

    task automatic feed(input int n, input bit gaps);
        int k = 0;
        int t = 0;
        while (k < n && t < 2000) begin
            vec_in_valid = gaps ? (t % 2 == 0) : 1'b1;
            vec_in_data  = 64'hD0 + 64'(k);
            #1;
            if (vec_in_valid && vec_in_ready) k++;
            @(posedge clk); #1;
            t++;
        end
        vec_in_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && n_done == 0; i++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (n_done == 0) begin
            n_err++;
            $display("FAIL done_timeout: no done within %0d cycles", bound);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({cmd_ready, vec_in_ready, vrf_we, mvu_en, mvu_first, mvu_last, orf_we, busy, done} !== 9'b1_0000_0000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 100000000",
                     {cmd_ready, vec_in_ready, vrf_we, mvu_en, mvu_first, mvu_last, orf_we, busy, done});
        end
        n_checks++;
        if ({vrf_wr_addr, vrf_rd_addr, mrf_rd_addr, orf_wr_addr, vrf_wr_data} !== '0) begin
            n_err++;
            $display("FAIL reset_addr: got %h/%h/%h/%h data %h want all 0",
                     vrf_wr_addr, vrf_rd_addr, mrf_rd_addr, orf_wr_addr, vrf_wr_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        do_cmd(4, 2, 5);
        n_checks++;
        if ({busy, vec_in_ready, cmd_ready} !== 3'b110) begin
            n_err++;
            $display("FAIL basic_load_state: busy/ready/cmd_ready got %b want 110", {busy, vec_in_ready, cmd_ready});
        end
        feed(4, 1'b0);
        wait_done(60);
        n_checks++;
        if (q_vw_addr.size() != 4) begin
            n_err++; $display("FAIL basic_vrf_count: got %0d want 4", q_vw_addr.size());
        end
        for (int i = 0; i < 4 && i < q_vw_addr.size(); i++) begin
            n_checks++;
            if (q_vw_addr[i] != i || q_vw_cyc[i] != acc_cyc + 1 + i || q_vw_data[i] !== 64'hD0 + 64'(i)) begin
                n_err++;
                $display("FAIL basic_vrf_wr[%0d]: addr %0d cyc %0d data %h want addr %0d cyc %0d data %h",
                         i, q_vw_addr[i], q_vw_cyc[i], q_vw_data[i], i, acc_cyc + 1 + i, 64'hD0 + 64'(i));
            end
        end
        n_checks++;
        if (q_b_mrf.size() != 8) begin
            n_err++; $display("FAIL basic_beat_count: got %0d want 8", q_b_mrf.size());
        end
        for (int i = 0; i < 8 && i < q_b_mrf.size(); i++) begin
            n_checks++;
            if (q_b_mrf[i] != i || q_b_vrf[i] != i % 4 || q_b_cyc[i] != acc_cyc + 5 + i ||
                q_b_fl[i] !== {i % 4 == 0, i % 4 == 3}) begin
                n_err++;
                $display("FAIL basic_beat[%0d]: mrf %0d vrf %0d fl %b cyc %0d want mrf %0d vrf %0d fl %b cyc %0d",
                         i, q_b_mrf[i], q_b_vrf[i], q_b_fl[i], q_b_cyc[i],
                         i, i % 4, {i % 4 == 0, i % 4 == 3}, acc_cyc + 5 + i);
            end
        end
        n_checks++;
        if (q_o_addr.size() != 2 || q_o_addr[0] != 5 || q_o_cyc[0] != acc_cyc + 18 ||
            q_o_addr[1] != 6 || q_o_cyc[1] != acc_cyc + 22) begin
            n_err++;
            $display("FAIL basic_orf: n %0d cyc-acc %0d,%0d want n 2 addr 5@18 6@22",
                     q_o_addr.size(), q_o_cyc.size() > 0 ? q_o_cyc[0] - acc_cyc : -1,
                     q_o_cyc.size() > 1 ? q_o_cyc[1] - acc_cyc : -1);
        end
        n_checks++;
        if (n_done != 1 || done_cyc != acc_cyc + 23) begin
            n_err++;
            $display("FAIL basic_done: n %0d at +%0d want 1 at +23", n_done, done_cyc - acc_cyc);
        end
        n_checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            n_err++; $display("FAIL basic_idle_after: cmd_ready/busy got %b want 10", {cmd_ready, busy});
        end
    endtask

    task automatic test_stall();
        do_cmd(3, 1, 0);
        feed(3, 1'b1);
        wait_done(60);
        n_checks++;
        if (q_vw_addr.size() != 3) begin
            n_err++; $display("FAIL stall_vrf_count: got %0d want 3", q_vw_addr.size());
        end
        for (int i = 0; i < 3 && i < q_vw_addr.size(); i++) begin
            n_checks++;
            if (q_vw_addr[i] != i || q_vw_cyc[i] != acc_cyc + 1 + 2 * i) begin
                n_err++;
                $display("FAIL stall_vrf_wr[%0d]: addr %0d at +%0d want %0d at +%0d",
                         i, q_vw_addr[i], q_vw_cyc[i] - acc_cyc, i, 1 + 2 * i);
            end
        end
        n_checks++;
        if (q_b_cyc.size() != 3 || q_b_cyc[0] != acc_cyc + 6) begin
            n_err++;
            $display("FAIL stall_compute_start: beats %0d first at +%0d want 3 at +6",
                     q_b_cyc.size(), q_b_cyc.size() > 0 ? q_b_cyc[0] - acc_cyc : -1);
        end
        n_checks++;
        if (q_o_cyc.size() != 1 || q_o_cyc[0] != acc_cyc + 18 || done_cyc != acc_cyc + 19) begin
            n_err++;
            $display("FAIL stall_wb: orf n %0d done at +%0d want 1 write at +18 done +19",
                     q_o_cyc.size(), done_cyc - acc_cyc);
        end
    endtask

    task automatic test_zero_len();
        do_cmd(0, 3, 0);
        wait_done(20);
        n_checks++;
        if (done_cyc != acc_cyc + 1 || q_vw_addr.size() != 0 || q_b_cyc.size() != 0 || q_o_cyc.size() != 0) begin
            n_err++;
            $display("FAIL zero_vlen: done +%0d vrf %0d beats %0d orf %0d want +1 0 0 0",
                     done_cyc - acc_cyc, q_vw_addr.size(), q_b_cyc.size(), q_o_cyc.size());
        end
        do_cmd(4, 0, 0);
        wait_done(20);
        n_checks++;
        if (done_cyc != acc_cyc + 1 || q_vw_addr.size() != 0 || q_b_cyc.size() != 0 || q_o_cyc.size() != 0) begin
            n_err++;
            $display("FAIL zero_ntiles: done +%0d vrf %0d beats %0d orf %0d want +1 0 0 0",
                     done_cyc - acc_cyc, q_vw_addr.size(), q_b_cyc.size(), q_o_cyc.size());
        end
    endtask

    task automatic test_wrap();
        do_cmd(1, 2, 511);
        feed(1, 1'b0);
        wait_done(60);
        n_checks++;
        if (q_b_fl.size() != 2 || q_b_fl[0] !== 2'b11 || q_b_fl[1] !== 2'b11 || q_b_mrf[1] != 1) begin
            n_err++;
            $display("FAIL wrap_beats: n %0d fl %b %b want 2 beats 11 11 mrf 0,1",
                     q_b_fl.size(), q_b_fl.size() > 0 ? q_b_fl[0] : 2'bxx, q_b_fl.size() > 1 ? q_b_fl[1] : 2'bxx);
        end
        n_checks++;
        if (q_o_addr.size() != 2 || q_o_addr[0] != 511 || q_o_addr[1] != 0 ||
            q_o_cyc[0] != acc_cyc + 12 || q_o_cyc[1] != acc_cyc + 13) begin
            n_err++;
            $display("FAIL wrap_orf: n %0d addr %0d,%0d want 511@+12, 0@+13", q_o_addr.size(),
                     q_o_addr.size() > 0 ? q_o_addr[0] : -1, q_o_addr.size() > 1 ? q_o_addr[1] : -1);
        end
        n_checks++;
        if (done_cyc != acc_cyc + 14) begin
            n_err++; $display("FAIL wrap_done: at +%0d want +14", done_cyc - acc_cyc);
        end
    endtask

    task automatic test_clamp();
        do_cmd(600, 1, 2);
        feed(512, 1'b0);
        wait_done(1200);
        n_checks++;
        if (q_vw_addr.size() != 512 || q_vw_addr[511] != 511) begin
            n_err++; $display("FAIL clamp_load: words %0d want 512 ending at 511", q_vw_addr.size());
        end
        n_checks++;
        if (q_b_fl.size() != 512 || q_b_fl[0] !== 2'b10 || q_b_fl[511] !== 2'b01) begin
            n_err++; $display("FAIL clamp_beats: beats %0d want 512 first/last at ends", q_b_fl.size());
        end
        n_checks++;
        if (q_o_addr.size() != 1 || q_o_addr[0] != 2 || done_cyc != acc_cyc + 1035) begin
            n_err++;
            $display("FAIL clamp_wb: orf n %0d done +%0d want 1 write addr 2 done +1035",
                     q_o_addr.size(), done_cyc - acc_cyc);
        end
    endtask

    task automatic test_reset_abort();
        do_cmd(2, 5, 7);
        feed(2, 1'b0);
        while (cyc < acc_cyc + 9) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (q_b_fl.size() != 6 || q_o_cyc.size() != 0 || !mvu_en) begin
            n_err++;
            $display("FAIL abort_precond: beats %0d orf %0d en %b want 6 0 1", q_b_fl.size(), q_o_cyc.size(), mvu_en);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({cmd_ready, vec_in_ready, vrf_we, mvu_en, mvu_first, mvu_last, orf_we, busy, done} !== 9'b1_0000_0000 ||
            {vrf_wr_addr, vrf_rd_addr, mrf_rd_addr, orf_wr_addr} !== '0) begin
            n_err++;
            $display("FAIL abort_outputs: ctrl %b addrs %h %h %h %h want 100000000 and zeros",
                     {cmd_ready, vec_in_ready, vrf_we, mvu_en, mvu_first, mvu_last, orf_we, busy, done},
                     vrf_wr_addr, vrf_rd_addr, mrf_rd_addr, orf_wr_addr);
        end
        clear_mon();
        repeat (25) @(posedge clk);
        #1;
        n_checks++;
        if (q_o_cyc.size() != 0 || q_b_cyc.size() != 0 || q_vw_cyc.size() != 0 || n_done != 0) begin
            n_err++;
            $display("FAIL abort_quiet: orf %0d beats %0d vrf %0d done %0d want all 0",
                     q_o_cyc.size(), q_b_cyc.size(), q_vw_cyc.size(), n_done);
        end
    endtask

`ifdef MVU_SEQ_CTRL_VEC_REUSE_EN
    task automatic test_reuse();
        do_cmd(4, 1, 0);
        feed(4, 1'b0);
        wait_done(60);
        vec_in_valid = 1'b1;
        cmd_reuse    = 1'b1;
        do_cmd(7, 2, 0);
        cmd_reuse    = 1'b0;
        wait_done(60);
        vec_in_valid = 1'b0;
        n_checks++;
        if (n_rdy != 0 || q_vw_addr.size() != 0) begin
            n_err++; $display("FAIL reuse_noload: ready cycles %0d writes %0d want 0 0", n_rdy, q_vw_addr.size());
        end
        n_checks++;
        if (q_b_fl.size() != 8 || q_b_fl[3] !== 2'b01 || q_b_fl[4] !== 2'b10 || q_b_fl[7] !== 2'b01 ||
            q_b_cyc[0] != acc_cyc + 1) begin
            n_err++; $display("FAIL reuse_beats: beats %0d want 8 with 4 per tile from +1", q_b_fl.size());
        end
        n_checks++;
        if (done_cyc != acc_cyc + 19) begin
            n_err++; $display("FAIL reuse_done: at +%0d want +19", done_cyc - acc_cyc);
        end
    endtask
`endif

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_wrap();
        test_clamp();
        test_reset_abort();
`ifdef MVU_SEQ_CTRL_VEC_REUSE_EN
        test_reuse();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
